memory_write_control: RTL and testbench
=======================================

# memory_write_control

Write-side counterpart of the frame memory controller's display reader. It accepts a raster video stream (vsync/hsync/de/pixel), pairs two adjacent lines through an internal half-line buffer, and packs each 2x2 pixel block into one MEM_WIDTH frame-memory word. It then issues an active-low write to the frame memory, using the same word layout and addressing that the display read path consumes.

## Interface
- DATA_WIDTH, 24, bits per pixel
- MEM_WIDTH, DATA_WIDTH*4, frame memory word (one 2x2 block)
- ADDR_DEPTH, 512*512/4, frame memory words
- ADDR_WIDTH, $clog2(ADDR_DEPTH), write address width
- MAX_HRES, 512, line buffer sizing (MAX_HRES/2 entries of 2*DATA_WIDTH)
- i_clk  input  1  pixel clock
- rst_n  input  1  reset, asynchronous, active-low
- i_vsync  input  1  frame sync; rising edge starts a frame
- i_hsync  input  1  line sync (timing only, not used for counting)
- i_de  input  1  pixel valid
- i_data  input  DATA_WIDTH  pixel
- i_hres  input  11  active pixels per line (even, <= MAX_HRES)
- i_vres  input  11  active lines per frame (even)
- o_wen  output  1  frame memory write enable, active-low
- o_waddr  output  ADDR_WIDTH  word address
- o_wdata  output  MEM_WIDTH  packed 2x2 block
- o_frame_done  output  1  one-cycle pulse with the frame's last write

## Operation
- FSM states: S_WIDLE, S_EVEN, S_ODD. Reset -> S_WIDLE.
- The block detects a rising edge of i_vsync by registering the previous value. In any state, this edge moves the FSM to S_EVEN and sets rowCnt=0 and colCnt=0.
- colCnt increments on each i_de=1 cycle. On i_de falling edge: colCnt<=0 and rowCnt<=rowCnt+1.
- Falling edge of i_de: S_EVEN -> S_ODD. S_ODD -> S_EVEN, or S_ODD -> S_WIDLE if the completed row equals i_vres-1.
- In S_WIDLE, i_de is ignored. This covers extra lines and lines before the first vsync.
- S_EVEN behaviour:
  - Even col: the pixel is held in a staging register.
  - Odd col: {staged, i_data} is written to linebuf[colCnt>>1].
  - No memory write occurs.
- S_ODD behaviour:
  - Even col: the pixel is staged.
  - Odd col: a memory write is issued.
  - o_wdata[72+:24]=linebuf even-col pixel; [48+:24]=linebuf odd-col pixel; [24+:24]=staged; [0+:24]=i_data.
  - o_waddr = (rowCnt>>1)*(i_hres>>1) + (colCnt>>1), computed at full width and truncated to ADDR_WIDTH.
- A trailing unpaired pixel (colCnt >= i_hres, or an odd line length) is dropped and never written.
- o_frame_done pulses together with the write where rowCnt==i_vres-1 and colCnt==i_hres-1.

## Timing
- Reset values: o_wen=1, o_waddr=0, o_wdata=0, o_frame_done=0. FSM=S_WIDLE, counters=0. Line buffer contents are not reset.
- Write latency: o_wen=0 in the cycle after the odd-line odd-column pixel is sampled. o_waddr and o_wdata are valid in that same cycle. All outputs are registered.
- o_wen is low for exactly one cycle per write. Back-to-back writes are spaced at most every 2 cycles.
- The line buffer is read combinationally at index colCnt>>1 during the odd-column cycle. The even-line entry for a given index is written no later than 1 cycle after its pixel, so it is always valid before the matching odd-line read.
- A vsync edge in the same cycle as i_de=1: the frame restart takes priority, and that pixel is counted as colCnt 0 of row 0.
- Reset mid-frame: all outputs return to reset values immediately. Any pending write is discarded. Capture resumes at the next vsync rising edge.

## Configuration
- Macro FMC_WR_LINE_CHECK_EN.
- Defined:
  - Adds output o_err (1 bit, reset 0).
  - At each i_de falling edge, a final colCnt != i_hres sets o_err.
  - o_err is sticky until the next vsync rising edge.
  - If an S_EVEN line is short, all writes for the following S_ODD line are suppressed.
- Undefined: no o_err port and no length checking. Writes are issued as data arrives.

## Test plan
- Frame with hres=4, vres=4, pixel=row*16+col, hsync/de blanking of 4 cycles. Expect:
  - addr0 = {0x00,0x01,0x10,0x11}, addr1 = {0x02,0x03,0x12,0x13}
  - addr2 = {0x20,0x21,0x30,0x31}, addr3 = {0x22,0x23,0x32,0x33}
  - o_frame_done with the addr3 write
- o_wen checks: o_wen=1 throughout even lines; o_wen=0 exactly 1 cycle after each odd-line odd-column pixel.
- Second vsync edge after 1 line of a new frame, then a full frame: addresses restart at 0 with no stale writes.
- Six de lines with vres=4: lines 4-5 produce no writes (S_WIDLE).
- rst_n low during row 1 col 1, then a new frame: outputs go to reset values, the pending write is lost, and the new frame writes from addr 0.
- With FMC_WR_LINE_CHECK_EN, a 3-pixel row 0 at hres=4: o_err=1, row 1 produces no writes, and o_err clears at the next vsync.

Source files
------------

// File: rtl/memory_write_control.sv
// Packs 2x2 pixel blocks of a raster stream into frame-memory words via a half-line buffer.
// Optional feature macro: FMC_WR_LINE_CHECK_EN (line-length checking, o_err, write suppression).
module memory_write_control #(
    parameter int unsigned DATA_WIDTH = 24,
    parameter int unsigned MEM_WIDTH  = DATA_WIDTH * 4,
    parameter int unsigned ADDR_DEPTH = 512 * 512 / 4,
    parameter int unsigned ADDR_WIDTH = $clog2(ADDR_DEPTH),
    parameter int unsigned MAX_HRES   = 512
) (
    input  logic                  i_clk,
    input  logic                  rst_n,
    input  logic                  i_vsync,
    input  logic                  i_hsync,
    input  logic                  i_de,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic [10:0]           i_hres,
    input  logic [10:0]           i_vres,
    output logic                  o_wen,
    output logic [ADDR_WIDTH-1:0] o_waddr,
    output logic [MEM_WIDTH-1:0]  o_wdata,
`ifdef FMC_WR_LINE_CHECK_EN
    output logic                  o_err,
`endif
    output logic                  o_frame_done
);

    localparam int unsigned LbDepth = MAX_HRES / 2;
    localparam int unsigned LbIdxW  = $clog2(LbDepth);
    localparam int unsigned AddrFullW = 23;

    typedef enum logic [1:0] {S_WIDLE, S_EVEN, S_ODD} state_e;

    state_e                  r_state;
    logic                    r_vsync_d;
    logic                    r_de_d;
    logic [10:0]             r_row;
    logic [10:0]             r_col;
    logic [DATA_WIDTH-1:0]   r_stage;
    logic [2*DATA_WIDTH-1:0] r_linebuf [LbDepth];

    logic                    w_vs_rise;
    logic                    w_de_fall;
    logic                    w_in_line;
    logic                    w_pix;
    logic                    w_lb_we;
    logic                    w_wr;
    logic                    w_wr_ok;
    logic                    w_last_row;
    logic [LbIdxW-1:0]       w_lb_idx;
    logic [2*DATA_WIDTH-1:0] w_lb_rd;
    logic [ADDR_WIDTH-1:0]   w_waddr;
    logic                    w_unused;

    // hsync carries timing only; line boundaries come from de edges.
    assign w_unused   = i_hsync;

    assign w_vs_rise  = i_vsync & ~r_vsync_d;
    assign w_de_fall  = r_de_d & ~i_de;
    assign w_in_line  = r_col < i_hres;
    assign w_pix      = i_de && (r_state != S_WIDLE) && w_in_line && !w_vs_rise;
    assign w_lb_we    = w_pix && (r_state == S_EVEN) && r_col[0];
    assign w_wr       = w_pix && (r_state == S_ODD) && r_col[0] && w_wr_ok;
    assign w_last_row = (r_row == i_vres - 11'd1);
    assign w_lb_idx   = r_col[LbIdxW:1];
    assign w_lb_rd    = r_linebuf[w_lb_idx];
    assign w_waddr    = ADDR_WIDTH'(AddrFullW'(r_row >> 1) * AddrFullW'(i_hres >> 1)
                                    + AddrFullW'(r_col >> 1));

    // Even-line pixel pairs; deliberately not reset.
    always_ff @(posedge i_clk) begin
        if (w_lb_we) begin
            r_linebuf[w_lb_idx] <= {r_stage, i_data};
        end
    end

`ifdef FMC_WR_LINE_CHECK_EN
    logic r_skip;

    always_ff @(posedge i_clk or negedge rst_n) begin
        if (!rst_n) begin
            o_err  <= 1'b0;
            r_skip <= 1'b0;
        end else if (w_vs_rise) begin
            o_err  <= 1'b0;
            r_skip <= 1'b0;
        end else if (w_de_fall && (r_state != S_WIDLE)) begin
            if (r_col != i_hres) begin
                o_err <= 1'b1;
            end
            // A short even line leaves stale buffer entries, so its odd partner is not written.
            r_skip <= (r_state == S_EVEN) && (r_col != i_hres);
        end
    end

    assign w_wr_ok = ~r_skip;
`else
    assign w_wr_ok = 1'b1;
`endif

    always_ff @(posedge i_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_WIDLE;
            r_vsync_d    <= 1'b1;
            r_de_d       <= 1'b0;
            r_row        <= '0;
            r_col        <= '0;
            r_stage      <= '0;
            o_wen        <= 1'b1;
            o_waddr      <= '0;
            o_wdata      <= '0;
            o_frame_done <= 1'b0;
        end else begin
            r_vsync_d    <= i_vsync;
            r_de_d       <= i_de;
            o_wen        <= 1'b1;
            o_frame_done <= 1'b0;
            if (w_vs_rise) begin
                // Frame restart wins; a coincident pixel becomes column 0 of row 0.
                r_state <= S_EVEN;
                r_row   <= '0;
                r_col   <= i_de ? 11'd1 : 11'd0;
                if (i_de) begin
                    r_stage <= i_data;
                end
            end else if (r_state != S_WIDLE) begin
                if (w_de_fall) begin
                    r_col <= '0;
                    r_row <= r_row + 11'd1;
                    if (r_state == S_EVEN) begin
                        r_state <= S_ODD;
                    end else begin
                        r_state <= w_last_row ? S_WIDLE : S_EVEN;
                    end
                end else if (i_de) begin
                    r_col <= r_col + 11'd1;
                    if (w_in_line && !r_col[0]) begin
                        r_stage <= i_data;
                    end
                    if (w_wr) begin
                        o_wen        <= 1'b0;
                        o_waddr      <= w_waddr;
                        o_wdata      <= {w_lb_rd, r_stage, i_data};
                        o_frame_done <= w_last_row && (r_col == i_hres - 11'd1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_memory_write_control.sv
// Scoreboard bench for memory_write_control: a frame-level model predicts every memory write.
module tb_memory_write_control;

    localparam int DW = 24;
    localparam int MW = 96;
    localparam int AW = 16;

    logic          i_clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          i_vsync = 1'b0;
    logic          i_hsync = 1'b0;
    logic          i_de = 1'b0;
    logic [DW-1:0] i_data = '0;
    logic [10:0]   i_hres = 11'd4;
    logic [10:0]   i_vres = 11'd4;
    logic          o_wen;
    logic [AW-1:0] o_waddr;
    logic [MW-1:0] o_wdata;
    logic          o_frame_done;
`ifdef FMC_WR_LINE_CHECK_EN
    logic          o_err;
`endif

    memory_write_control dut (
        .i_clk        (i_clk),
        .rst_n        (rst_n),
        .i_vsync      (i_vsync),
        .i_hsync      (i_hsync),
        .i_de         (i_de),
        .i_data       (i_data),
        .i_hres       (i_hres),
        .i_vres       (i_vres),
        .o_wen        (o_wen),
        .o_waddr      (o_waddr),
        .o_wdata      (o_wdata),
`ifdef FMC_WR_LINE_CHECK_EN
        .o_err        (o_err),
`endif
        .o_frame_done (o_frame_done)
    );

    always #5 i_clk = ~i_clk;

    int unsigned cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    typedef struct {
        logic [AW-1:0] addr;
        logic [MW-1:0] data;
        logic          done;
        int unsigned   cyc;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   n_tests = 0;
    int   n_fail  = 0;

    // Frame-level reference state
    int          m_row, m_hres, m_vres;
    bit          m_active = 0;
    bit          m_err = 0;
    bit          m_skip = 0;
    logic [DW-1:0] prev_line [1024];
    logic [DW-1:0] cur_line  [1024];

    task automatic chk(input string name, input logic [MW-1:0] got, input logic [MW-1:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic model_restart(input int hres, input int vres);
        m_row    = 0;
        m_hres   = hres;
        m_vres   = vres;
        m_active = 1;
        m_err    = 0;
        m_skip   = 0;
    endtask

    task automatic new_frame(input int hres, input int vres);
        i_hres = 11'(hres);
        i_vres = 11'(vres);
        tick();
        i_vsync = 1'b1;
        model_restart(hres, vres);
        tick();
        tick();
        i_vsync = 1'b0;
        tick();
    endtask

    task automatic drive_line(input int len, input int blank, input bit pattern, input bit vs_first);
        exp_t x;
        logic [DW-1:0] d;
        for (int c = 0; c < len; c++) begin
            tick();
            i_de    = 1'b1;
            i_hsync = 1'b0;
            if (c == 0 && vs_first) begin
                i_vsync = 1'b1;
                model_restart(int'(i_hres), int'(i_vres));
            end
            d = pattern ? DW'(m_row * 16 + c) : DW'($urandom);
            i_data = d;
            cur_line[c] = d;
            // A 2x2 block completes at every odd column of an odd line inside the frame.
            if (m_active && (m_row % 2 == 1) && (c % 2 == 1) && (c < m_hres) && !m_skip) begin
                x.addr = AW'((m_row / 2) * (m_hres / 2) + c / 2);
                x.data = {prev_line[c-1], prev_line[c], cur_line[c-1], cur_line[c]};
                x.done = (m_row == m_vres - 1) && (c == m_hres - 1);
                x.cyc  = cyc + 1;
                q.push_back(x);
            end
        end
        tick();
        i_de    = 1'b0;
        i_vsync = 1'b0;
        i_hsync = 1'b1;
        if (m_active) begin
            if (len != m_hres) m_err = 1;
`ifdef FMC_WR_LINE_CHECK_EN
            m_skip = (m_row % 2 == 0) && (len != m_hres);
`endif
            if (m_row == m_vres - 1) m_active = 0;
            m_row++;
        end
        for (int c = 0; c < len; c++) prev_line[c] = cur_line[c];
        for (int b = 0; b < blank; b++) begin
            tick();
            i_hsync = 1'b0;
        end
`ifdef FMC_WR_LINE_CHECK_EN
        chk("o_err_line", MW'(o_err), MW'(m_err));
`endif
    endtask

    always @(negedge i_clk) begin
        if (rst_n) begin
            if (!o_wen) begin
                n_tests++;
                if (q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_write: addr=%0h data=%0h done=%0b cyc=%0d, no write expected",
                             o_waddr, o_wdata, o_frame_done, cyc);
                end else begin
                    e = q.pop_front();
                    if (o_waddr !== e.addr || o_wdata !== e.data || o_frame_done !== e.done
                        || cyc != e.cyc) begin
                        n_fail++;
                        $display("FAIL write: addr=%0h data=%0h done=%0b cyc=%0d expected addr=%0h data=%0h done=%0b cyc=%0d",
                                 o_waddr, o_wdata, o_frame_done, cyc, e.addr, e.data, e.done, e.cyc);
                    end
                end
            end else if (o_frame_done) begin
                n_tests++;
                n_fail++;
                $display("FAIL frame_done_no_write: got 1 expected 0 at cyc=%0d", cyc);
            end
        end
    end

    initial begin
        int hres, vres, lines, len;
        bit vsf;

        // Reset values
        tick();
        chk("rst_wen", MW'(o_wen), MW'(1));
        chk("rst_waddr", MW'(o_waddr), MW'(0));
        chk("rst_wdata", o_wdata, MW'(0));
        chk("rst_done", MW'(o_frame_done), MW'(0));
`ifdef FMC_WR_LINE_CHECK_EN
        chk("rst_err", MW'(o_err), MW'(0));
`endif
        tick();
        rst_n = 1'b1;
        tick();

        // Lines before any vsync are ignored
        drive_line(4, 4, 1, 0);

        // Directed 4x4 pattern frame
        new_frame(4, 4);
        for (int r = 0; r < 4; r++) drive_line(4, 4, 1, 0);

        // Restart after one line, then a full frame
        new_frame(4, 4);
        drive_line(4, 4, 1, 0);
        new_frame(4, 4);
        for (int r = 0; r < 4; r++) drive_line(4, 4, 1, 0);

        // Six lines with vres=4: last two land in idle
        new_frame(4, 4);
        for (int r = 0; r < 6; r++) drive_line(4, 3, 1, 0);

        // Reset at row 1 col 1: the pending write is lost
        new_frame(4, 4);
        drive_line(4, 4, 1, 0);
        tick();
        i_de = 1'b1;
        i_data = 24'h10;
        tick();
        i_data = 24'h11;
        rst_n = 1'b0;
        tick();
        i_de = 1'b0;
        chk("midrst_wen", MW'(o_wen), MW'(1));
        chk("midrst_waddr", MW'(o_waddr), MW'(0));
        chk("midrst_wdata", o_wdata, MW'(0));
        chk("midrst_done", MW'(o_frame_done), MW'(0));
        tick();
        rst_n = 1'b1;
        m_active = 0;
        drive_line(4, 3, 1, 0);
        new_frame(4, 4);
        for (int r = 0; r < 4; r++) drive_line(4, 4, 1, 0);

`ifdef FMC_WR_LINE_CHECK_EN
        // Short even line: error flagged, partner line suppressed, cleared at next vsync
        new_frame(4, 4);
        drive_line(3, 4, 1, 0);
        for (int r = 1; r < 4; r++) drive_line(4, 4, 1, 0);
        new_frame(4, 4);
        chk("err_clear", MW'(o_err), MW'(0));
`endif

        // Randomized frames, including vsync coincident with the first pixel
        for (int f = 0; f < 25; f++) begin
            hres  = 2 * $urandom_range(1, 12);
            vres  = 2 * $urandom_range(1, 4);
            lines = vres + $urandom_range(0, 2);
            vsf   = ($urandom_range(0, 3) == 0);
            new_frame(hres, vres);
            for (int r = 0; r < lines; r++) begin
                len = (r % 2 == 0) ? hres + $urandom_range(0, 1) : hres - 1 + $urandom_range(0, 2);
                drive_line(len, $urandom_range(1, 5), 0, vsf && r == 0);
            end
        end

        // Full-width frame exercises the whole line buffer
        new_frame(512, 2);
        drive_line(512, 3, 0, 0);
        drive_line(513, 3, 0, 0);

        for (int i = 0; i < 10; i++) tick();
        chk("drain_pending", MW'(q.size()), MW'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
